// File: rtl/diagnosis_report_streamer_pkg.sv
// +----------------------------------------------------------------------+
// | diag_pkg                                                             |
// | Shared state encoding, ASCII framing constants and size defaults.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package diag_pkg;

  localparam int DEFAULT_NUM_CLASSES = 15;
  localparam int DEFAULT_NAME_LENGTH = 32;

  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_QMARK = 8'h3F;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_PREFIX = 3'd2,
    ST_NAME   = 3'd3,
    ST_CRLF   = 3'd4
`ifdef CONF_REPORT_EN
    , ST_CONF = 3'd5
`endif
  } state_e;

endpackage

`default_nettype wire

// File: rtl/diagnosis_report_streamer_if.sv
// +----------------------------------------------------------------------+
// | diagnosis_report_streamer_if                                         |
// | Classifier-result input handshake and ASCII byte output stream.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface diagnosis_report_streamer_if
  import diag_pkg::*;
#(
  parameter int CLASS_W = $clog2(DEFAULT_NUM_CLASSES)
);

  logic               result_valid;
  logic               result_ready;
  logic [CLASS_W-1:0] result_class;
  logic [7:0]         result_conf;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  // slave is the streamer; master is the classifier plus the byte sink
  modport slave (
    input  result_valid, result_class, result_conf, tx_ready,
    output result_ready, tx_data, tx_valid
  );

  modport master (
    output result_valid, result_class, result_conf, tx_ready,
    input  result_ready, tx_data, tx_valid
  );

endinterface

`default_nettype wire

// File: rtl/diagnosis_report_streamer_bin8_to_bcd.sv
// +----------------------------------------------------------------------+
// | bin8_to_bcd                                                          |
// | Combinational double-dabble: 8-bit binary to three BCD digits.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bin8_to_bcd (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [19:0] shift;

  always_comb begin
    shift = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (shift[11:8] >= 4'd5)  shift[11:8]  = shift[11:8]  + 4'd3;
      if (shift[15:12] >= 4'd5) shift[15:12] = shift[15:12] + 4'd3;
      if (shift[19:16] >= 4'd5) shift[19:16] = shift[19:16] + 4'd3;
      shift = shift << 1;
    end
    hundreds = shift[19:16];
    tens     = shift[15:12];
    ones     = shift[11:8];
  end

endmodule

`default_nettype wire

// File: rtl/diagnosis_report_streamer.sv
// +----------------------------------------------------------------------+
// | diagnosis_report_streamer                                            |
// | Frames each classifier result as "DX:<name>\r\n" over a byte stream. |
// | Define CONF_REPORT_EN to append " ddd" confidence before the CRLF.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module diagnosis_report_streamer
  import diag_pkg::*;
#(
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int NAME_LENGTH = DEFAULT_NAME_LENGTH,
  parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  diagnosis_report_streamer_if.slave bus,
  output logic [CLASS_W-1:0]       rom_class_index,
  input  logic [NAME_LENGTH*8-1:0] rom_disease_name,
  input  logic                     rom_name_valid,
  output logic                     busy,
  output logic                     msg_done
);

  localparam int IDX_W = $clog2(NAME_LENGTH);

`ifdef CONF_REPORT_EN
  localparam state_e NAME_NEXT = ST_CONF;
`else
  localparam state_e NAME_NEXT = ST_CRLF;
`endif

  state_e                   state_q, state_d;
  logic [1:0]               sub_q, sub_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [NAME_LENGTH*8-1:0] name_q, name_d;
  logic                     qmark_q, qmark_d;
  logic [CLASS_W-1:0]       class_q, class_d;

  logic [IDX_W-1:0]         scan_first, scan_last;
  logic                     scan_found;
  logic [7:0]               cur_byte;
  logic                     tx_valid_c;
  logic [7:0]               tx_data_c;
  logic                     tx_fire;

`ifdef CONF_REPORT_EN
  logic [7:0] conf_q, conf_d;
  logic [3:0] bcd_h, bcd_t, bcd_o;

  bin8_to_bcd u_bcd (
    .bin      (conf_q),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );
`else
  logic conf_unused;
  assign conf_unused = ^bus.result_conf;
`endif

  // Byte 0 of a name sits in the most significant byte lane
  always_comb begin
    scan_first = '0;
    scan_last  = '0;
    scan_found = 1'b0;
    for (int i = NAME_LENGTH - 1; i >= 0; i--) begin
      if (rom_disease_name[(NAME_LENGTH-1-i)*8 +: 8] != 8'h00)
        scan_first = IDX_W'(i);
    end
    for (int i = 0; i < NAME_LENGTH; i++) begin
      if (rom_disease_name[(NAME_LENGTH-1-i)*8 +: 8] != 8'h00 &&
          rom_disease_name[(NAME_LENGTH-1-i)*8 +: 8] != CH_SPACE) begin
        scan_last  = IDX_W'(i);
        scan_found = 1'b1;
      end
    end
  end

  assign cur_byte = name_q[(NAME_LENGTH-1-int'(idx_q))*8 +: 8];
  assign tx_fire  = tx_valid_c && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sub_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      name_q  <= '0;
      qmark_q <= 1'b0;
      class_q <= '0;
`ifdef CONF_REPORT_EN
      conf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      name_q  <= name_d;
      qmark_q <= qmark_d;
      class_q <= class_d;
`ifdef CONF_REPORT_EN
      conf_q  <= conf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    last_d  = last_q;
    name_d  = name_q;
    qmark_d = qmark_q;
    class_d = class_q;
`ifdef CONF_REPORT_EN
    conf_d  = conf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.result_valid) begin
          class_d = bus.result_class;
`ifdef CONF_REPORT_EN
          conf_d  = bus.result_conf;
`endif
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        name_d  = rom_disease_name;
        qmark_d = !rom_name_valid || !scan_found;
        idx_d   = scan_first;
        last_d  = scan_last;
        sub_d   = '0;
        state_d = ST_PREFIX;
      end
      ST_PREFIX: begin
        if (tx_fire) begin
          if (sub_q == 2'd2) begin
            sub_d   = '0;
            state_d = ST_NAME;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      ST_NAME: begin
        // Interior NULs are stepped over without a transfer
        if (qmark_q) begin
          if (tx_fire) state_d = NAME_NEXT;
        end else if (cur_byte == 8'h00) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (tx_fire) begin
          if (idx_q == last_q) state_d = NAME_NEXT;
          else                 idx_d   = idx_q + IDX_W'(1);
        end
      end
`ifdef CONF_REPORT_EN
      ST_CONF: begin
        if (tx_fire) begin
          if (sub_q == 2'd3) begin
            sub_d   = '0;
            state_d = ST_CRLF;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
`endif
      ST_CRLF: begin
        if (tx_fire) begin
          if (sub_q == 2'd1) begin
            sub_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_c       = 1'b0;
    tx_data_c        = 8'h00;
    bus.result_ready = 1'b0;
    busy             = 1'b1;
    msg_done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.result_ready = 1'b1;
        busy             = 1'b0;
      end
      ST_PREFIX: begin
        tx_valid_c = 1'b1;
        tx_data_c  = (sub_q == 2'd0) ? CH_D : (sub_q == 2'd1) ? CH_X : CH_COLON;
      end
      ST_NAME: begin
        if (qmark_q) begin
          tx_valid_c = 1'b1;
          tx_data_c  = CH_QMARK;
        end else if (cur_byte != 8'h00) begin
          tx_valid_c = 1'b1;
          tx_data_c  = cur_byte;
        end
      end
`ifdef CONF_REPORT_EN
      ST_CONF: begin
        tx_valid_c = 1'b1;
        case (sub_q)
          2'd0:    tx_data_c = CH_SPACE;
          2'd1:    tx_data_c = CH_ZERO | {4'h0, bcd_h};
          2'd2:    tx_data_c = CH_ZERO | {4'h0, bcd_t};
          default: tx_data_c = CH_ZERO | {4'h0, bcd_o};
        endcase
      end
`endif
      ST_CRLF: begin
        tx_valid_c = 1'b1;
        tx_data_c  = (sub_q == 2'd0) ? CH_CR : CH_LF;
        msg_done   = (sub_q == 2'd1) && bus.tx_ready;
      end
      default: ;
    endcase
  end

  assign bus.tx_valid    = tx_valid_c;
  assign bus.tx_data     = tx_data_c;
  assign rom_class_index = class_q;

endmodule

`default_nettype wire

// File: tb/tb_diagnosis_report_streamer.sv
// +----------------------------------------------------------------------+
// | tb_diagnosis_report_streamer                                         |
// | Self-checking bench: vector table, corner sequences, random messages.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_diagnosis_report_streamer;

  localparam int NL = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  diagnosis_report_streamer_if #(.CLASS_W(CW)) bus ();

  logic [CW-1:0]   rom_idx;
  logic [NL*8-1:0] rom_name;
  logic            rom_vld;
  logic            busy;
  logic            msg_done;

  diagnosis_report_streamer #(
    .NUM_CLASSES (15),
    .NAME_LENGTH (NL),
    .CLASS_W     (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .rom_class_index  (rom_idx),
    .rom_disease_name (rom_name),
    .rom_name_valid   (rom_vld),
    .busy             (busy),
    .msg_done         (msg_done)
  );

  logic [NL*8-1:0] rom_mem [16];
  logic            rom_override;
  logic [NL*8-1:0] rom_rand;
  string           names [16];

  always_comb begin
    rom_name = rom_override ? rom_rand : rom_mem[rom_idx];
    rom_vld  = (rom_idx < 4'd15);
  end

  int checks = 0;
  int failures = 0;
  int last_wait;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];

  typedef struct {
    logic [3:0] cls;
    logic [7:0] conf;
    int         mode;
    string      name;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input bit ok, input string nm, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", nm, act, req);
    end
  endtask

  function automatic logic [NL*8-1:0] pack_name(input string s, input bit nul_pad);
    logic [NL*8-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++)
      v[(NL-1-k)*8 +: 8] = (k < s.len()) ? s[k] : (nul_pad ? 8'h00 : 8'h20);
    return v;
  endfunction

  function automatic string q2s(input byte unsigned q[$]);
    string s;
    s = "";
    foreach (q[k])
      if (q[k] >= 8'h20 && q[k] < 8'h7F) s = {s, $sformatf("%c", q[k])};
      else                               s = {s, $sformatf("\\x%02h", q[k])};
    return s;
  endfunction

  function automatic bit q_eq();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[k]) if (got_q[k] != exp_q[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_exp(input string nm, input logic [7:0] conf);
    string line;
    line = {"DX:", nm};
`ifdef CONF_REPORT_EN
    line = {line, $sformatf(" %03d", conf)};
`endif
    exp_q = {};
    for (int k = 0; k < line.len(); k++) exp_q.push_back(line[k]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Reference rule: drop leading NULs, cut after last printable, drop interior NULs
  task automatic model_exp(input logic [NL*8-1:0] nm, input bit vld, input logic [7:0] conf);
    byte unsigned b [NL];
    int f, l;
    string s;
    f = -1; l = -1; s = "";
    for (int k = 0; k < NL; k++) begin
      b[k] = nm[(NL-1-k)*8 +: 8];
      if (f < 0 && b[k] != 0) f = k;
      if (b[k] != 0 && b[k] != 8'h20) l = k;
    end
    if (!vld || l < 0) s = "?";
    else for (int k = f; k <= l; k++) if (b[k] != 0) s = {s, $sformatf("%c", b[k])};
    build_exp(s, conf);
  endtask

  // mode: 0 ready high, 1 ready toggles 1010, 2 random ready
  task automatic stream(input logic [3:0] cls, input logic [7:0] conf, input int mode,
                        input bit pend, input logic [3:0] pcls, input logic [7:0] pconf,
                        input string label);
    int wait_cyc, cyc, first_v, stallbad, rrbad;
    bit prev_stall, done;
    byte unsigned prev_data;
    bus.result_valid = 1'b1;
    bus.result_class = cls;
    bus.result_conf  = conf;
    wait_cyc = 0;
    @(negedge clk);
    while (!bus.result_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    last_wait = wait_cyc;
    @(posedge clk); #1;
    if (pend) begin
      bus.result_class = pcls;
      bus.result_conf  = pconf;
    end else begin
      bus.result_valid = 1'b0;
    end
    got_q = {}; cyc = 1; first_v = 0; stallbad = 0; rrbad = 0;
    prev_stall = 1'b0; prev_data = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      case (mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = (cyc % 2 == 1);
        default: bus.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (bus.tx_valid && first_v == 0) first_v = cyc;
      if (prev_stall && (!bus.tx_valid || bus.tx_data != prev_data)) stallbad++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.result_ready) rrbad++;
      if (msg_done) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check(first_v == 2, {label, "_latency"}, $sformatf("%0d", first_v), "2");
    check(done, {label, "_msg_done"}, "no pulse", "one pulse");
    check(q_eq(), {label, "_bytes"}, q2s(got_q), q2s(exp_q));
    check(stallbad == 0, {label, "_stall_hold"}, $sformatf("%0d", stallbad), "0");
    check(rrbad == 0, {label, "_ready_low"}, $sformatf("%0d", rrbad), "0");
    check(!busy && bus.result_ready, {label, "_idle_after"},
          $sformatf("busy=%0b rr=%0b", busy, bus.result_ready), "busy=0 rr=1");
  endtask

  initial begin
    logic [3:0] cls;
    logic [7:0] conf;
    int n, k;
    rst_n = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_class = '0;
    bus.result_conf  = '0;
    bus.tx_ready     = 1'b0;
    rom_override     = 1'b0;
    rom_rand         = '0;
    names = '{"No Finding", "Atelectasis", "Cardiomegaly", "Effusion", "Infiltration",
              "Mass", "Nodule", "Pneumonia", "Pleural Thickening", "Pneumothorax",
              "Consolidation", "Emphysema", "Edema", "Fibrosis", "Hernia", "Invalid Entry"};
    for (int c = 0; c < 16; c++) rom_mem[c] = pack_name(names[c], (c % 2) == 0);

    tbl[0] = '{4'd0,  8'd200, 0, "No Finding"};
    tbl[1] = '{4'd8,  8'd42,  1, "Pleural Thickening"};
    tbl[2] = '{4'd15, 8'd9,   0, "?"};
    tbl[3] = '{4'd14, 8'd87,  1, "Hernia"};
    tbl[4] = '{4'd14, 8'd255, 0, "Hernia"};
    tbl[5] = '{4'd3,  8'd0,   2, "Effusion"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(bus.result_ready === 1'b1 && bus.tx_valid === 1'b0 && bus.tx_data === 8'h00 &&
          busy === 1'b0 && msg_done === 1'b0 && rom_idx === 4'd0, "reset_state",
          $sformatf("rr=%0b txv=%0b txd=%02h busy=%0b done=%0b idx=%0d", bus.result_ready,
                    bus.tx_valid, bus.tx_data, busy, msg_done, rom_idx),
          "rr=1 txv=0 txd=00 busy=0 done=0 idx=0");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      build_exp(tbl[i].name, tbl[i].conf);
      stream(tbl[i].cls, tbl[i].conf, tbl[i].mode, 1'b0, 4'd0, 8'd0, $sformatf("vec%0d", i));
    end

    // Second result held while busy; accepted one cycle after msg_done
    build_exp("Cardiomegaly", 8'd10);
    stream(4'd2, 8'd10, 0, 1'b1, 4'd6, 8'd77, "bp_first");
    build_exp("Nodule", 8'd77);
    stream(4'd6, 8'd77, 1, 1'b0, 4'd0, 8'd0, "bp_second");
    check(last_wait == 0, "bp_accept_delay", $sformatf("%0d", last_wait), "0");

    // Reset after the 5th byte of class 5
    bus.result_valid = 1'b1;
    bus.result_class = 4'd5;
    bus.result_conf  = 8'd33;
    bus.tx_ready     = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.result_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    bus.result_valid = 1'b0;
    n = 0; k = 0;
    while (n < 5 && k < 50) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) n++;
      @(posedge clk); #1;
      k++;
    end
    check(n == 5, "rst_mid_bytes", $sformatf("%0d", n), "5");
    rst_n = 1'b0;
    #1;
    check(bus.tx_valid === 1'b0 && bus.tx_data === 8'h00 && busy === 1'b0 &&
          msg_done === 1'b0 && bus.result_ready === 1'b1 && rom_idx === 4'd0, "rst_mid_outputs",
          $sformatf("txv=%0b txd=%02h busy=%0b done=%0b rr=%0b idx=%0d", bus.tx_valid,
                    bus.tx_data, busy, msg_done, bus.result_ready, rom_idx),
          "txv=0 txd=00 busy=0 done=0 rr=1 idx=0");
    @(negedge clk);
    rst_n = 1'b1;
    build_exp("Edema", 8'd120);
    stream(4'd12, 8'd120, 0, 1'b0, 4'd0, 8'd0, "after_rst");

    // Random classes, confidences, ready patterns and ROM contents
    for (int r = 0; r < 30; r++) begin
      cls  = 4'($urandom_range(0, 15));
      conf = 8'($urandom_range(0, 255));
      rom_override = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NL; b++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3)      rom_rand[(NL-1-b)*8 +: 8] = 8'h00;
        else if (sel < 5) rom_rand[(NL-1-b)*8 +: 8] = 8'h20;
        else              rom_rand[(NL-1-b)*8 +: 8] = 8'(8'h61 + $urandom_range(0, 25));
      end
      if ($urandom_range(0, 5) == 0)
        for (int b = 0; b < NL; b++) rom_rand[(NL-1-b)*8 +: 8] = (b % 3 == 0) ? 8'h20 : 8'h00;
      model_exp(rom_override ? rom_rand : rom_mem[cls], cls < 4'd15, conf);
      stream(cls, conf, 2, 1'b0, 4'd0, 8'd0, $sformatf("rnd%0d", r));
      rom_override = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/diagnosis_report_streamer.md
Name: diagnosis_report_streamer

Overview:
Converts each classifier result (class index plus 8-bit confidence) into a printable ASCII report line and streams it one byte at a time over a valid/ready byte interface. The UART TX path is the intended consumer. It drives the index input of the disease-names ROM, captures the returned 32-byte name, drops NUL padding and trailing spaces, and frames the line as "DX:<name>\r\n". It sits between the MobileNetV3 argmax/classifier output and the host serial link.

Parameters:
NUM_CLASSES, 15, number of diagnosis classes; ROM depth.
NAME_LENGTH, 32, characters per ROM name entry.
CLASS_W, $clog2(NUM_CLASSES), class index width (4 at default).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
result_valid  in  1  classifier result available
result_ready  out  1  streamer can accept a result
result_class  in  CLASS_W  predicted class index
result_conf  in  8  confidence, 0-255
rom_class_index  out  CLASS_W  index driven to the names ROM (registered)
rom_disease_name  in  NAME_LENGTH*8  ROM name; first character in MSB byte
rom_name_valid  in  1  ROM index-in-range flag
tx_data  out  8  ASCII byte
tx_valid  out  1  byte valid
tx_ready  in  1  sink accepts byte
busy  out  1  high from result accept until the last byte is accepted
msg_done  out  1  one-cycle pulse when the final '\n' is accepted

Behaviour:
- Reset (async, rst_n low): state IDLE; result_ready=1; tx_valid=0; tx_data=0; busy=0; msg_done=0; rom_class_index=0. All counters and latches clear. A reset mid-message aborts the line silently and does not emit a partial CRLF.
- FSM states: IDLE, LOOKUP, PREFIX, NAME, CONF (feature only), CRLF.
- IDLE: result_ready=1. On result_valid&&result_ready, latch class and confidence, register rom_class_index, and go to LOOKUP. busy is high from the next cycle.
- LOOKUP (1 cycle): treat the ROM as combinational. Capture rom_disease_name and rom_name_valid. Compute first_idx (first byte that is not 0x00) and last_idx (last byte that is neither 0x20 nor 0x00). Byte 0 is the MSB byte. If rom_name_valid=0 or no printable byte exists, substitute the name "?". Go to PREFIX.
- Latency: the first tx_valid ('D') is asserted 2 cycles after the accept cycle.
- PREFIX: emit 'D', 'X', ':' in that order, then go to NAME.
- NAME: emit bytes first_idx..last_idx in order. Interior 0x00 bytes are skipped; each skip costs one cycle with tx_valid=0. Interior spaces are emitted. After last_idx, go to CONF or CRLF.
- CRLF: emit 0x0D then 0x0A. When the 0x0A is accepted, pulse msg_done and return to IDLE. busy falls the same cycle.
- Handshake: a byte transfers when tx_valid&&tx_ready. While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops without a transfer. Back-to-back transfers reach 1 byte/cycle.
- result_ready=0 in every state except IDLE. Results arriving while busy are back-pressured, not dropped. msg_done and a new accept can never occur in the same cycle; the new accept comes one cycle after msg_done at the earliest.
- Byte counter is 5 bits wide (0..NAME_LENGTH-1) and never wraps; NAME exits on index==last_idx.

Optional Feature:
CONF_REPORT_EN. When defined, the CONF state inserts a space followed by three zero-padded decimal digits of result_conf before the CRLF, e.g. conf 87 gives " 087". When undefined, the CONF state and the BCD logic are absent and NAME goes directly to CRLF.

Decomposition:
- Shared package diag_pkg holds:
  - the state enum;
  - the ASCII constants CH_D, CH_X, CH_COLON, CH_SPACE, CH_QMARK, CH_CR, CH_LF, CH_ZERO;
  - the NUM_CLASSES and NAME_LENGTH defaults.
- One sub-module, bin8_to_bcd: a combinational double-dabble converter from 8-bit binary to three 4-bit digits. It is instantiated only under CONF_REPORT_EN.

Test Plan:
- Class 0, tx_ready tied high: exactly 15 bytes "DX:No Finding\r\n" on consecutive cycles. First tx_valid is 2 cycles after accept. One msg_done pulse.
- Class 8, tx_ready toggling 1010...: bytes "DX:Pleural Thickening\r\n" with tx_data stable through every stall and no bytes lost or duplicated.
- Class 15 (out of range, rom_name_valid=0): "DX:?\r\n".
- Second result_valid asserted while busy: result_ready stays 0. That result is accepted one cycle after msg_done and streams fully afterwards.
- rst_n pulsed low after the 5th byte of class 5: outputs return to their reset values immediately. The next result, class 12, streams "DX:Edema\r\n" cleanly.
- With CONF_REPORT_EN, class 14, conf 87: "DX:Hernia 087\r\n". Conf 255 gives " 255" and conf 0 gives " 000".
